// File: rtl/tx_packet_fsm.sv
// rtl/tx_packet_fsm.sv - packet transmit sequencer: SYNC, PID, data, CRC16, EOP
// Optional CRC-16/USB generator over the data bytes is enabled by TX_CRC16_GEN_EN.
module tx_packet_fsm (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_data,
    input  logic       byte_done,
    input  logic       eop_done,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic       get_tx_data,
    output logic       tx_eop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] ptype;
    logic [6:0] remaining;
    logic       legal;
    logic       accept;
    logic       is_data;
    logic       load_next;
    logic       pop_next;
    logic       error_next;
    logic [7:0] byte_next;
    logic [7:0] pid_byte;
    logic [7:0] crc_lo;
    logic [7:0] crc_hi;

    assign legal   = (tx_packet >= 3'd1) && (tx_packet <= 3'd5) &&
                     ((tx_packet >= 3'd3) || (buffer_occupancy <= 7'd64));
    assign accept  = (state == IDLE) && tx_start && legal;
    assign is_data = (ptype == 3'd1) || (ptype == 3'd2);

    always_comb begin
        pid_byte = 8'h00;
        case (ptype)
            3'd1:    pid_byte = 8'hC3;
            3'd2:    pid_byte = 8'h4B;
            3'd3:    pid_byte = 8'hD2;
            3'd4:    pid_byte = 8'h5A;
            3'd5:    pid_byte = 8'h1E;
            default: pid_byte = 8'h00;
        endcase
    end

`ifdef TX_CRC16_GEN_EN
    logic [15:0] crc;

    // Reflected CRC-16 (0xA001), one byte, LSB first to match wire order.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= 16'hFFFF;
        end else if (accept) begin
            crc <= 16'hFFFF;
        end else if (pop_next) begin
            crc <= crc16_byte(crc, tx_data);
        end
    end

    assign crc_lo = ~crc[7:0];
    assign crc_hi = ~crc[15:8];
`else
    assign crc_lo = 8'h00;
    assign crc_hi = 8'h00;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            tx_byte     <= 8'h00;
            tx_load     <= 1'b0;
            get_tx_data <= 1'b0;
            tx_error    <= 1'b0;
            ptype       <= 3'd0;
            remaining   <= 7'd0;
        end else begin
            state       <= next_state;
            tx_byte     <= byte_next;
            tx_load     <= load_next;
            get_tx_data <= pop_next;
            tx_error    <= error_next;
            if (accept) begin
                ptype     <= tx_packet;
                remaining <= (tx_packet <= 3'd2) ? buffer_occupancy : 7'd0;
            end else if (pop_next) begin
                remaining <= remaining - 7'd1;
            end
        end
    end

    // Loads are decided here and registered, so tx_load lands in the first cycle of each state.
    always_comb begin
        next_state = state;
        load_next  = 1'b0;
        pop_next   = 1'b0;
        error_next = 1'b0;
        byte_next  = tx_byte;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    if (legal) begin
                        next_state = SYNC;
                        load_next  = 1'b1;
                        byte_next  = 8'h80;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            SYNC: begin
                if (byte_done) begin
                    next_state = PID;
                    load_next  = 1'b1;
                    byte_next  = pid_byte;
                end
            end
            PID, DATA: begin
                if (byte_done) begin
                    if (!is_data) begin
                        next_state = EOP;
                    end else if (remaining != 7'd0) begin
                        next_state = DATA;
                        load_next  = 1'b1;
                        pop_next   = 1'b1;
                        byte_next  = tx_data;
                    end else begin
                        next_state = CRC_LO;
                        load_next  = 1'b1;
                        byte_next  = crc_lo;
                    end
                end
            end
            CRC_LO: begin
                if (byte_done) begin
                    next_state = CRC_HI;
                    load_next  = 1'b1;
                    byte_next  = crc_hi;
                end
            end
            CRC_HI: begin
                if (byte_done) begin
                    next_state = EOP;
                end
            end
            EOP: begin
                if (eop_done) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_busy = (state != IDLE) && (state != DONE);
        tx_done = (state == DONE);
        tx_eop  = (state == EOP);
    end

endmodule

// File: tb/tb_tx_packet_fsm.sv
// tb/tb_tx_packet_fsm.sv - directed self-checking bench for tx_packet_fsm
module tb_tx_packet_fsm;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [2:0] tx_packet = 3'd0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] tx_data;
    logic       byte_done = 1'b0;
    logic       eop_done = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       get_tx_data;
    logic       tx_eop;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int checks = 0;
    int errors = 0;

`ifdef TX_CRC16_GEN_EN
    localparam logic [7:0] CRC_LO_E = 8'hC8;
    localparam logic [7:0] CRC_HI_E = 8'hB4;
`else
    localparam logic [7:0] CRC_LO_E = 8'h00;
    localparam logic [7:0] CRC_HI_E = 8'h00;
`endif

    logic [7:0] mem [0:511];
    int         head = 0;
    logic [7:0] loads [$];
    logic [7:0] exp_q [$];
    int gets = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, eop_total = 0;
    int bd_wait = 0, eop_wait = 0;

    tx_packet_fsm dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_packet(tx_packet),
        .buffer_occupancy(buffer_occupancy), .tx_data(tx_data),
        .byte_done(byte_done), .eop_done(eop_done), .tx_byte(tx_byte),
        .tx_load(tx_load), .get_tx_data(get_tx_data), .tx_eop(tx_eop),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    // First-word-fall-through buffer model: head advances on the pop edge.
    assign tx_data = mem[head];
    always @(posedge clk) if (n_rst && get_tx_data) head <= head + 1;

    // Shifter/encoder model and activity recorder.
    always @(negedge clk) begin
        byte_done = 1'b0;
        eop_done  = 1'b0;
        if (!n_rst) begin
            bd_wait  = 0;
            eop_wait = 0;
        end else begin
            if (tx_load) begin
                loads.push_back(tx_byte);
                bd_wait = 3;
            end else if (bd_wait != 0) begin
                bd_wait--;
                if (bd_wait == 0) byte_done = 1'b1;
            end
            if (tx_eop) begin
                eop_total++;
                eop_wait++;
                if (eop_wait == 2) eop_done = 1'b1;
            end else begin
                eop_wait = 0;
            end
            if (get_tx_data) gets++;
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
            if (tx_busy) busy_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_pkt(input logic [2:0] t, input logic [6:0] occ);
        @(negedge clk);
        tx_packet = t;
        buffer_occupancy = occ;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!tx_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, tx_done, 1);
        check({tag, "_busy_at_done"}, tx_busy, 0);
        @(negedge clk);
    endtask

    task automatic check_seq(input string tag, input int base);
        check({tag, "_nloads"}, loads.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < loads.size(); i++)
            check({tag, "_byte"}, loads[base + i], exp_q[i]);
    endtask

    task automatic fill_digits();
        for (int i = 0; i < 9; i++) mem[head + i] = 8'h31 + 8'(i);
    endtask

    initial begin
        int lb, gb, db, eb, bb, eo, n;
        logic [2:0] bad_t [2];
        logic [6:0] bad_o [2];

        repeat (2) @(negedge clk);
        check("reset_outputs", {tx_byte, tx_load, get_tx_data, tx_eop, tx_busy, tx_done, tx_error}, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // ACK handshake
        lb = loads.size(); gb = gets; db = done_cnt; eo = eop_total;
        start_pkt(3'd3, 7'd0);
        #1;
        check("ack_first_load", {tx_load, tx_busy, tx_byte}, {1'b1, 1'b1, 8'h80});
        wait_done("ack");
        exp_q = '{8'h80, 8'hD2};
        check_seq("ack", lb);
        check("ack_gets", gets - gb, 0);
        check("ack_done_cnt", done_cnt - db, 1);
        check("ack_eop_seen", (eop_total - eo) >= 2, 1);

        // DATA0 "123456789"
        fill_digits();
        lb = loads.size(); gb = gets; db = done_cnt;
        start_pkt(3'd1, 7'd9);
        wait_done("d0");
        exp_q = '{8'h80, 8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  CRC_LO_E, CRC_HI_E};
        check_seq("d0", lb);
        check("d0_gets", gets - gb, 9);

        // DATA1 empty
        lb = loads.size(); gb = gets;
        start_pkt(3'd2, 7'd0);
        wait_done("d1_empty");
        exp_q = '{8'h80, 8'h4B, 8'h00, 8'h00};
        check_seq("d1_empty", lb);
        check("d1_empty_gets", gets - gb, 0);

        // Rejected requests
        bad_t = '{3'd6, 3'd1};
        bad_o = '{7'd0, 7'd65};
        for (int k = 0; k < 2; k++) begin
            lb = loads.size(); eb = err_cnt; bb = busy_cnt;
            start_pkt(bad_t[k], bad_o[k]);
            #1;
            check("rej_error_pulse", tx_error, 1);
            check("rej_busy", tx_busy, 0);
            repeat (10) @(negedge clk);
            check("rej_err_cnt", err_cnt - eb, 1);
            check("rej_loads", loads.size() - lb, 0);
            check("rej_busy_cnt", busy_cnt - bb, 0);
        end

        // Reset after the 3rd data byte of a 64-byte DATA0
        for (int i = 0; i < 64; i++) mem[head + i] = 8'(i + 8'h10);
        lb = loads.size();
        start_pkt(3'd1, 7'd64);
        n = 0;
        while (loads.size() < lb + 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_3rd", loads.size() >= lb + 5, 1);
        n_rst = 1'b0;
        #1;
        check("rst_mid_outputs", {tx_byte, tx_load, get_tx_data, tx_eop, tx_busy, tx_done, tx_error}, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_resume", tx_busy, 0);

        lb = loads.size(); gb = gets;
        start_pkt(3'd4, 7'd0);
        wait_done("nak");
        exp_q = '{8'h80, 8'h5A};
        check_seq("nak", lb);
        check("nak_gets", gets - gb, 0);

        // tx_start during DATA must be ignored
        fill_digits();
        lb = loads.size(); gb = gets; db = done_cnt;
        start_pkt(3'd1, 7'd9);
        n = 0;
        while (loads.size() < lb + 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tx_packet = 3'd3;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_done("ign");
        repeat (20) @(negedge clk);
        exp_q = '{8'h80, 8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  CRC_LO_E, CRC_HI_E};
        check_seq("ign", lb);
        check("ign_gets", gets - gb, 9);
        check("ign_done_cnt", done_cnt - db, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
